pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the fixed-width combinational carry-lookahead adders in the arithmetic library.
- Splits a WIDTH-bit operation into BLOCK-bit CLA groups, with one group resolved per pipeline stage and the carry registered between stages.
- Adds add/subtract and signed/unsigned modes, carry/borrow-in, an overflow flag and a valid/ready stream interface.
- Sits between operand sources and consumers in datapaths that need a high clock rate.

Parameters:
- WIDTH, 12, operand width in bits (>=2).
- BLOCK, 4, CLA group width in bits (1..WIDTH). The last group holds the remaining WIDTH-(NB-1)*BLOCK bits.
- NB (localparam) = ceil(WIDTH/BLOCK), the number of pipeline stages and the latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in in add mode, borrow-in in sub mode.
- in_sub  in  1  1 = A-B, 0 = A+B.
- in_signed  in  1  1 = two's-complement interpretation.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  result. Bit WIDTH is defined under Behaviour.
- out_ovf  out  1  overflow/borrow flag.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits cleared; out_valid=0.
  - out_sum=0, out_ovf=0; in_ready=1 once rst_n=1.
  - In-flight data is discarded. Nothing partial is emitted after reset deasserts.
- Operand prep at acceptance (in_valid&in_ready):
  - b' = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? ~in_cin : in_cin.
  - a, b', c0 and the mode bits are captured into stage 0.
- Stage k (0..NB-1):
  - Computes group k with cla_block using the carry registered from stage k-1 (c0 for k=0).
  - Sum bits of resolved groups and the unresolved operand bits travel down the pipe.
  - A per-stage valid bit travels alongside.
- Timing:
  - Latency is exactly NB cycles from the acceptance edge to out_valid=1, with no stall.
  - Throughput is 1 transaction per cycle.
- Flow control:
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall=1 every stage register holds, including out_*.
  - Bubbles are not collapsed.
- Result MSB, out_sum[WIDTH] (s = low WIDTH bits, c = carry out of bit WIDTH-1, ci = carry into bit WIDTH-1):
  - unsigned add: c.
  - unsigned sub: ~c, the borrow.
  - signed: a[W-1]^b'[W-1]^c, the exact sign of the (WIDTH+1)-bit result.
- out_ovf:
  - unsigned add: c.
  - unsigned sub: ~c.
  - signed: ci^c.
- Boundary cases:
  - Simultaneous acceptance and emission is the normal steady state.
  - out_valid stays high and out_* stay stable while out_ready=0.
  - out_ready ignored when out_valid=0.
  - A stall with empty pipe stages is impossible by construction.
  - WIDTH==BLOCK gives NB=1: one registered stage, latency 1.

Decomposition:
- Package arith_pkg:
  - function ceil_div.
  - typedef for the mode struct {sub, signed}.
  - localparams for the flag encoding.
- Sub-module cla_block, parametrised by GW:
  - inputs a[GW], b[GW], cin.
  - outputs sum[GW], cout, c_msb_in (carry into the group MSB, used only by the last group).
  - Generated NB times inside a generate loop.

Test Plan:
- WIDTH=12, BLOCK=4, unsigned add 0xFFF+0x001, cin=0, out_ready=1 -> 3 cycles later out_sum=0x1000, out_ovf=1.
- Signed add 0x7FF+0x001 -> out_sum=0x0800, out_ovf=1. Signed 0x800+0xFFF -> out_sum=0x17FF, out_ovf=1. Signed 0x003+0xFFE -> out_sum=0x0001, out_ovf=0.
- Unsigned sub 0x005-0x007, cin=0 -> out_sum=0x1FFE, out_ovf=1. Sub 0x007-0x005 with borrow-in cin=1 -> out_sum=0x0001, out_ovf=0.
- Stream of 8 back-to-back transactions with A=i, B=2i, out_ready=1 -> results 3i emitted on consecutive cycles in order, in_ready constantly 1.
- Same stream with out_ready=0 for cycles 4..7 -> in_ready=0 and out_* stable during the stall, no loss or duplication, order preserved.
- Two transactions in flight, rst_n pulsed low for 1 cycle -> out_valid=0 immediately. No output for the 5 cycles after release; a new transaction then completes with latency 3.
- Random sweep over parameter pairs (WIDTH,BLOCK) in {(12,4),(13,4),(8,8),(16,3)} against a reference model -> zero mismatches over 10k transactions.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared arithmetic definitions: operating-mode struct, mode/flag encodings
// and the elaboration-time helper that sizes the pipeline.
package arith_pkg;

  typedef struct packed {
    logic sub;
    logic sgn;
  } mode_t;

  localparam logic MODE_ADD     = 1'b0;
  localparam logic MODE_SUB     = 1'b1;
  localparam logic REP_UNSIGNED = 1'b0;
  localparam logic REP_SIGNED   = 1'b1;

  // Bit positions inside the two-bit result flag vector.
  localparam int FLAG_MSB = 0;
  localparam int FLAG_OVF = 1;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder.
// valid/ready: a word moves on a rising edge where valid and ready are both 1;
// in_ready is a combinational function of out_ready (global stall).
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 12
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_signed, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_signed, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// One GW-bit carry-lookahead group: every carry is formed directly from the
// group's generate/propagate terms and cin, not rippled bit to bit.
module cla_block #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  input  logic          cin,
  output logic [GW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  logic [GW-1:0] g;
  logic [GW-1:0] p;
  logic [GW:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = cin.p[0..i-1] | OR over j<i of g[j].p[j+1..i-1]
  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= GW; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
  end

  assign sum      = p ^ c[GW-1:0];
  assign cout     = c[GW];
  assign c_msb_in = c[GW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one BLOCK-bit CLA group resolved per stage with the
// group carry registered in between; the last group feeds the outputs.
module pipelined_cla_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BLOCK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_cla_adder_if.slave io
);

  localparam int NB      = ceil_div(WIDTH, BLOCK);
  localparam int LAST_GW = WIDTH - (NB - 1) * BLOCK;
  localparam int L       = NB - 1;

  logic [NB-1:0]            vld_q;
  logic [NB-1:0][WIDTH-1:0] a_q;
  logic [NB-1:0][WIDTH-1:0] b_q;
  logic [NB-1:0][WIDTH-1:0] s_q;
  logic [NB-1:0]            c_q;
  mode_t [NB-1:0]           mode_q;

  logic [NB-1:0][WIDTH-1:0] s_nxt;
  logic [NB-1:0]            cout_w;
  logic [NB-1:0]            cmsb_w;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_d;
  logic             c0_d;
  mode_t            mode_d;

  assign stall       = vld_q[L] & ~io.out_ready;
  assign io.in_ready = ~stall;
  assign accept      = io.in_valid & ~stall;

  // Subtraction is A + ~B + 1; a borrow-in removes that +1.
  assign b_d        = (io.in_sub == MODE_SUB) ? ~io.in_b : io.in_b;
  assign c0_d       = (io.in_sub == MODE_SUB) ? ~io.in_cin : io.in_cin;
  assign mode_d.sub = io.in_sub;
  assign mode_d.sgn = io.in_signed;

  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int LO = k * BLOCK;
    localparam int GW = (k == NB - 1) ? LAST_GW : BLOCK;
    localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - GW)) << LO;

    logic [GW-1:0] grp_sum;

    cla_block #(.GW(GW)) u_cla (
      .a        (a_q[k][LO +: GW]),
      .b        (b_q[k][LO +: GW]),
      .cin      (c_q[k]),
      .sum      (grp_sum),
      .cout     (cout_w[k]),
      .c_msb_in (cmsb_w[k])
    );

    assign s_nxt[k] = (s_q[k] & ~MASK) | (WIDTH'(grp_sum) << LO);
  end

  // Whole pipe advances together; bubbles shift like data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      mode_q <= '0;
    end else if (!stall) begin
      vld_q[0]  <= accept;
      a_q[0]    <= io.in_a;
      b_q[0]    <= b_d;
      s_q[0]    <= '0;
      c_q[0]    <= c0_d;
      mode_q[0] <= mode_d;
      for (int k = 1; k < NB; k++) begin
        vld_q[k]  <= vld_q[k-1];
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        s_q[k]    <= s_nxt[k-1];
        c_q[k]    <= cout_w[k-1];
        mode_q[k] <= mode_q[k-1];
      end
    end
  end

  logic [1:0] flags;
  logic       c_out;
  logic       c_in_msb;

  assign c_out    = cout_w[L];
  assign c_in_msb = cmsb_w[L];

  always_comb begin
    flags = '0;
    if (mode_q[L].sgn == REP_SIGNED) begin
      flags[FLAG_MSB] = a_q[L][WIDTH-1] ^ b_q[L][WIDTH-1] ^ c_out;
      flags[FLAG_OVF] = c_in_msb ^ c_out;
    end else if (mode_q[L].sub == MODE_SUB) begin
      flags[FLAG_MSB] = ~c_out;
      flags[FLAG_OVF] = ~c_out;
    end else begin
      flags[FLAG_MSB] = c_out;
      flags[FLAG_OVF] = c_out;
    end
  end

  assign io.out_valid = vld_q[L];
  assign io.out_sum   = {flags[FLAG_MSB], s_nxt[L]};
  assign io.out_ovf   = flags[FLAG_OVF];

  // Resolved/stale operand bits and inner-group MSB carries have no consumer.
  logic unused_sink;
  assign unused_sink = ^{a_q, b_q, s_q, cmsb_w};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed checks on a 12/4 instance and a
// randomized sweep over several WIDTH/BLOCK pairs against an arithmetic model.
module tb_pipelined_cla_adder;

  localparam int W  = 12;
  localparam int B  = 4;
  localparam int NB = 3;
  localparam int NTX = 2500;
  localparam int SW [4] = '{12, 13, 8, 16};
  localparam int SB [4] = '{4, 4, 8, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   sweep_go = 1'b0;
  int   sweep_finished = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder_if #(.WIDTH(W)) dif ();
  pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) dut (.clk(clk), .rst_n(rst_n), .io(dif));

  // Reference: exact integer result; returns {ovf, sum[w:0]}.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub, input logic sgn);
    longint av, bv, r, lo, hi;
    logic ovf;
    av = longint'(a);
    bv = longint'(b);
    if (sgn) begin
      if (a[w-1]) av = av - (longint'(1) << w);
      if (b[w-1]) bv = bv - (longint'(1) << w);
    end
    r = sub ? (av - bv - longint'(cin)) : (av + bv + longint'(cin));
    if (sgn) begin
      hi  = (longint'(1) << (w - 1)) - 1;
      lo  = -(longint'(1) << (w - 1));
      ovf = (r > hi) || (r < lo);
    end else if (sub) begin
      ovf = (r < 0);
    end else begin
      ovf = (r >= (longint'(1) << w));
    end
    return (longint'(ovf) << (w + 1)) | (r & ((longint'(1) << (w + 1)) - 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and per-cycle samples of the directed instance
  logic [63:0] exp_q[$];
  int          emit_cyc[$];
  logic        last_in_ready, last_in_acc, last_out_valid;
  logic [63:0] last_out;

  task automatic step();
    @(negedge clk);
    last_in_ready  = dif.in_ready;
    last_in_acc    = dif.in_valid && dif.in_ready;
    last_out_valid = dif.out_valid;
    last_out       = (64'(dif.out_ovf) << (W + 1)) | 64'(dif.out_sum);
    if (dif.out_valid && dif.out_ready) begin
      check("out_has_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        check("stream_result", last_out, exp_q.pop_front());
        emit_cyc.push_back(cyc);
      end
    end
    if (last_in_acc)
      exp_q.push_back(model(W, 32'(dif.in_a), 32'(dif.in_b), dif.in_cin, dif.in_sub, dif.in_signed));
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic cin, input logic sub, input logic sgn,
                         input logic [12:0] es, input logic eo);
    int lat;
    bit seen;
    dif.in_valid = 1'b1; dif.in_a = a; dif.in_b = b;
    dif.in_cin = cin; dif.in_sub = sub; dif.in_signed = sgn;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(dif.in_ready), 64'(1));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dif.out_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NB));
    check({tag, "_sum"}, 64'(dif.out_sum), 64'(es));
    check({tag, "_ovf"}, 64'(dif.out_ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          sent, k, span;
    logic [63:0] held;
    dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0;
    dif.in_cin = 1'b0; dif.in_sub = 1'b0; dif.in_signed = 1'b0;
    dif.out_ready = 1'b1;
    held = '0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(dif.out_valid), 64'(0));
    check("reset_out_sum", 64'(dif.out_sum), 64'(0));
    check("reset_out_ovf", 64'(dif.out_ovf), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset_in_ready", 64'(dif.in_ready), 64'(1));
    @(posedge clk);
    #1;

    run_one("u_add_fff_001", 12'hFFF, 12'h001, 1'b0, 1'b0, 1'b0, 13'h1000, 1'b1);
    run_one("s_add_7ff_001", 12'h7FF, 12'h001, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b1);
    run_one("s_add_800_fff", 12'h800, 12'hFFF, 1'b0, 1'b0, 1'b1, 13'h17FF, 1'b1);
    run_one("s_add_003_ffe", 12'h003, 12'hFFE, 1'b0, 1'b0, 1'b1, 13'h0001, 1'b0);
    run_one("u_sub_005_007", 12'h005, 12'h007, 1'b0, 1'b1, 1'b0, 13'h1FFE, 1'b1);
    run_one("u_sub_007_005_bin", 12'h007, 12'h005, 1'b1, 1'b1, 1'b0, 13'h0001, 1'b0);

    // Back-to-back stream, consumer always ready
    exp_q.delete(); emit_cyc.delete();
    dif.in_cin = 1'b0; dif.in_sub = 1'b0; dif.in_signed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dif.in_valid = 1'b1; dif.in_a = 12'(i); dif.in_b = 12'(2 * i);
      step();
      check("stream_in_ready", 64'(last_in_ready), 64'(1));
    end
    dif.in_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin step(); k++; end
    check("stream_drained", 64'(exp_q.size()), 64'(0));
    check("stream_count", 64'(emit_cyc.size()), 64'(8));
    span = (emit_cyc.size() > 0) ? emit_cyc[emit_cyc.size()-1] - emit_cyc[0] : -1;
    check("stream_consecutive", 64'(span), 64'(7));

    // Same stream with the consumer stalled for cycles 4..7
    exp_q.delete(); emit_cyc.delete();
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
      dif.in_valid  = (sent < 8);
      dif.in_a      = 12'(sent);
      dif.in_b      = 12'(2 * sent);
      dif.out_ready = !(c >= 4 && c <= 7);
      step();
      if (last_in_acc) sent++;
      if (c >= 4 && c <= 7) begin
        check("stall_in_ready", 64'(last_in_ready), 64'(0));
        check("stall_out_valid", 64'(last_out_valid), 64'(1));
        if (c == 4) held = last_out;
        else check("stall_out_hold", last_out, held);
      end
    end
    dif.in_valid = 1'b0; dif.out_ready = 1'b1;
    check("stall_sent", 64'(sent), 64'(8));
    check("stall_count", 64'(emit_cyc.size()), 64'(8));
    check("stall_drained", 64'(exp_q.size()), 64'(0));

    // Reset with two transactions in flight
    dif.out_ready = 1'b0;
    dif.in_valid = 1'b1; dif.in_a = 12'h001; dif.in_b = 12'h001;
    step();
    dif.in_a = 12'h002; dif.in_b = 12'h002;
    step();
    dif.in_valid = 1'b0;
    k = 0;
    while (!last_out_valid && k < 10) begin step(); k++; end
    check("rst_pre_out_valid", 64'(last_out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(dif.out_valid), 64'(0));
    check("rst_out_sum", 64'(dif.out_sum), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    dif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_quiet", 64'(last_out_valid), 64'(0));
    end
    run_one("post_rst_add", 12'h123, 12'h456, 1'b0, 1'b0, 1'b0, 13'h0579, 1'b0);

    sweep_go = 1'b1;
    k = 0;
    while (sweep_finished < 4 && k < 30000) begin @(posedge clk); k++; end
    check("sweep_all_done", 64'(sweep_finished), 64'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Randomized sweep, one instance per WIDTH/BLOCK pair
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SWW = SW[g];
    localparam int SBB = SB[g];
    localparam logic [31:0] MASK = (32'd1 << SWW) - 32'd1;

    pipelined_cla_adder_if #(.WIDTH(SWW)) sif ();
    pipelined_cla_adder #(.WIDTH(SWW), .BLOCK(SBB)) u_dut (.clk(clk), .rst_n(rst_n), .io(sif));

    logic [63:0] exp_q[$];

    initial begin
      int          acc_n, ncyc;
      logic [63:0] obs;
      string       tag;
      acc_n = 0; ncyc = 0;
      tag = $sformatf("sweep_w%0d_b%0d", SWW, SBB);
      sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0;
      sif.in_cin = 1'b0; sif.in_sub = 1'b0; sif.in_signed = 1'b0;
      sif.out_ready = 1'b0;
      wait (sweep_go);
      @(posedge clk);
      #1;
      while ((acc_n < NTX || exp_q.size() > 0) && ncyc < 20000) begin
        sif.in_valid  = (acc_n < NTX) && ($urandom_range(0, 3) != 0);
        sif.in_a      = SWW'($urandom & MASK);
        sif.in_b      = SWW'($urandom & MASK);
        sif.in_cin    = 1'($urandom_range(0, 1));
        sif.in_sub    = 1'($urandom_range(0, 1));
        sif.in_signed = 1'($urandom_range(0, 1));
        sif.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (sif.out_valid && sif.out_ready) begin
          check({tag, "_has_expected"}, 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            obs = (64'(sif.out_ovf) << (SWW + 1)) | 64'(sif.out_sum);
            check(tag, obs, exp_q.pop_front());
          end
        end
        if (sif.in_valid && sif.in_ready) begin
          exp_q.push_back(model(SWW, 32'(sif.in_a), 32'(sif.in_b),
                                sif.in_cin, sif.in_sub, sif.in_signed));
          acc_n++;
        end
        @(posedge clk);
        #1;
        ncyc++;
      end
      check({tag, "_completed"}, 64'(acc_n == NTX && exp_q.size() == 0), 64'(1));
      sif.in_valid = 1'b0;
      sweep_finished++;
    end
  end

endmodule
